audio_dac_serializer: RTL

//  Sink side of the codec write handshake (write_ready/write/writedata_left/right): buffers stereo

---
 rtl/audio_dac_serializer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/audio_dac_serializer.sv
// Stereo sample FIFO feeding an I2S serializer; codec-mastered BCLK/LRCK are
// synchronised into clk and AUD_DACDAT is shifted MSB-first on BCLK falls.
module audio_dac_serializer #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] writedata_left,
    input  logic [DATA_WIDTH-1:0] writedata_right,
    output logic                  write_ready,
    output logic [ADDR_WIDTH:0]   fifo_level,
    output logic                  underflow,
    input  logic                  AUD_BCLK,
    input  logic                  AUD_DACLRCK,
    output logic                  AUD_DACDAT
);

    localparam int unsigned DEPTH = 2**ADDR_WIDTH;
    localparam int unsigned CW    = $clog2(DATA_WIDTH + 2);

    localparam logic [ADDR_WIDTH:0]   FULL_LEVEL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   LVL_ONE    = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);
    localparam logic [CW-1:0]         CNT_ONE    = CW'(1);
    localparam logic [CW-1:0]         CNT_LAST   = CW'(DATA_WIDTH);
    localparam logic [CW-1:0]         CNT_SAT    = CW'(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LEFT,
        S_RIGHT
    } state_t;

    state_t                  state_q, state_d;
    logic [2:0]              bclk_sync_q;
    logic [2:0]              lrck_sync_q;
    logic [2*DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0]   wr_ptr_q, rd_ptr_q;
    logic [ADDR_WIDTH:0]     level_q, level_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   left_sr_q, left_sr_d;
    logic [DATA_WIDTH-1:0]   right_sr_q, right_sr_d;
    logic                    dacdat_q, dacdat_d;
    logic                    underflow_q, underflow_d;
    logic                    push, pop;
    logic                    bclk_fall, lrck_fall, lrck_rise;

    // [0],[1] are the two synchroniser stages; [2] is the previous synced value.
    assign bclk_fall = bclk_sync_q[2] & ~bclk_sync_q[1];
    assign lrck_fall = lrck_sync_q[2] & ~lrck_sync_q[1];
    assign lrck_rise = ~lrck_sync_q[2] & lrck_sync_q[1];

    assign write_ready = (level_q != FULL_LEVEL);
    assign push        = write && write_ready;
    assign fifo_level  = level_q;
    assign underflow   = underflow_q;
    assign AUD_DACDAT  = dacdat_q;

    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LVL_ONE;
        end else if (!push && pop) begin
            level_d = level_q - LVL_ONE;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        left_sr_d   = left_sr_q;
        right_sr_d  = right_sr_q;
        dacdat_d    = dacdat_q;
        underflow_d = 1'b0;
        pop         = 1'b0;
        // LRCK edges take priority over a coincident BCLK fall: 1-bit I2S delay slot.
        if (lrck_fall) begin
            state_d  = S_LEFT;
            cnt_d    = '0;
            dacdat_d = 1'b0;
            if (level_q != '0) begin
                pop        = 1'b1;
                left_sr_d  = mem_q[rd_ptr_q][2*DATA_WIDTH-1:DATA_WIDTH];
                right_sr_d = mem_q[rd_ptr_q][DATA_WIDTH-1:0];
            end else begin
                left_sr_d   = '0;
                right_sr_d  = '0;
                underflow_d = 1'b1;
            end
        end else if (lrck_rise) begin
            cnt_d    = '0;
            dacdat_d = 1'b0;
            if (state_q != S_IDLE) begin
                state_d = S_RIGHT;
            end
        end else if (bclk_fall && state_q != S_IDLE) begin
            if (cnt_q < CNT_LAST) begin
                cnt_d = cnt_q + CNT_ONE;
                if (state_q == S_LEFT) begin
                    dacdat_d  = left_sr_q[DATA_WIDTH-1];
                    left_sr_d = {left_sr_q[DATA_WIDTH-2:0], 1'b0};
                end else begin
                    dacdat_d   = right_sr_q[DATA_WIDTH-1];
                    right_sr_d = {right_sr_q[DATA_WIDTH-2:0], 1'b0};
                end
            end else begin
                cnt_d    = CNT_SAT;
                dacdat_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {writedata_left, writedata_right};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            bclk_sync_q <= '0;
            lrck_sync_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            cnt_q       <= '0;
            left_sr_q   <= '0;
            right_sr_q  <= '0;
            dacdat_q    <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bclk_sync_q <= {bclk_sync_q[1:0], AUD_BCLK};
            lrck_sync_q <= {lrck_sync_q[1:0], AUD_DACLRCK};
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            level_q     <= level_d;
            cnt_q       <= cnt_d;
            left_sr_q   <= left_sr_d;
            right_sr_q  <= right_sr_d;
            dacdat_q    <= dacdat_d;
            underflow_q <= underflow_d;
        end
    end

endmodule
